// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// and request legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_RD  = 3'd1,
    LD_RSP = 3'd2,
    ST_WR  = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5
  } lsu_state_t;

  // funct3[1:0] encodes the access width for both loads and stores
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store)
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane select with sign/zero extension, and
// sub-word store merge into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
    ld_half = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // untouched lanes keep the bits just read from memory
  always_comb begin
    st_word = mem_rdata;
    case (funct3)
      F3_B:    st_word[{addr_lo, 3'b000} +: 8]    = st_data[7:0];
      F3_H:    st_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      default: st_word = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between EX/MEM and a single-port word memory.
// state  | meaning
// IDLE   | accept/reject a request
// LD_RD  | load: memory read strobe
// LD_RSP | load: extract lane, pulse resp_valid
// ST_WR  | full-word store write
// RMW_RD | sub-word store: read target word
// RMW_WR | sub-word store: write merged word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  req_read,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  misaligned,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t            state;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           wdata_q;
  logic [31:0]           resp_q;
  logic                  misaligned_q;
  logic                  bad_req;
  logic [31:0]           ld_data;
  logic [31:0]           st_word;
  logic                  unused_addr_hi;

  // upper address bits wrap around the memory
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

  assign bad_req = lsu_pkg::misaligned(req_funct3, req_addr[1:0]) ||
                   !f3_legal(req_write, req_funct3);

  lsu_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .mem_rdata (mem_rdata),
    .st_data   (wdata_q),
    .ld_data   (ld_data),
    .st_word   (st_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && (req_write || req_read)) begin
            if (bad_req) begin
              misaligned_q <= 1'b1;
            end else begin
              addr_q  <= req_addr[DEPTH_LOG2+1:0];
              f3_q    <= req_funct3;
              wdata_q <= req_wdata;
              if (req_write)
                state <= (req_funct3 == F3_W) ? ST_WR : RMW_RD;
              else
                state <= LD_RD;
            end
          end
        end
        LD_RD:  state <= LD_RSP;
        LD_RSP: begin
          resp_q <= ld_data;
          state  <= IDLE;
        end
        ST_WR:  state <= IDLE;
        RMW_RD: state <= RMW_WR;
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall      = (state != IDLE);
  assign misaligned = misaligned_q;
  assign mem_re     = !rst && ((state == LD_RD) || (state == RMW_RD));
  assign mem_we     = !rst && ((state == ST_WR) || (state == RMW_WR));
  assign mem_addr   = rst ? '0 : addr_q[DEPTH_LOG2+1:2];
  assign resp_valid = !rst && (state == LD_RSP);

  always_comb begin
    mem_wdata = 32'h0;
    if (!rst) begin
      if (state == ST_WR)
        mem_wdata = wdata_q;
      else if (state == RMW_WR)
        mem_wdata = st_word;
    end
  end

  always_comb begin
    resp_rdata = resp_q;
    if (rst)
      resp_rdata = 32'h0;
    else if (state == LD_RSP)
      resp_rdata = ld_data;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// synchronous-read word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_read;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, misaligned;
  logic [31:0] resp_rdata;
  logic [4:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  int          we_cnt;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_LOG2(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_read(req_read),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic rd,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = wr; req_read = rd;
    req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
    tick(); tick();
    total++;
    if ({stall, resp_valid, misaligned, mem_re, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {stall, resp_valid, misaligned, mem_re, mem_we});
    end
    total++;
    if ({resp_rdata, mem_wdata, mem_addr} !== 69'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", resp_rdata, mem_wdata, mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sw();
    drive(1, 1, 0, F3_W, 32'h0000_0008, 32'hDEAD_BEEF);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL sw_accept_stall got=%b exp=0", stall); end
    tick();
    drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
    total++;
    if ({mem_we, mem_re, stall, mem_addr, mem_wdata} !== {3'b101, 5'd2, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL sw_c1 got we=%b re=%b st=%b a=%0d d=%h exp we=1 re=0 st=1 a=2 d=deadbeef",
                      mem_we, mem_re, stall, mem_addr, mem_wdata);
    end
    tick();
    total++;
    if ({stall, mem_we} !== 2'b00) begin bad++; $display("FAIL sw_c2 got st=%b we=%b exp 0 0", stall, mem_we); end
    total++;
    if (mem[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[2]); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{F3_B, F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [5] = '{32'h5, 32'h7, 32'h7, 32'h6, 32'h4};
    logic [31:0] exps [5] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    mem[1] = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, f3s[i], adrs[i], 32'h0);
      tick();
      drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
      total++;
      if ({mem_re, mem_we, stall, mem_addr} !== {3'b101, 5'd1}) begin
        bad++; $display("FAIL ld%0d_c1 got re=%b we=%b st=%b a=%0d exp re=1 we=0 st=1 a=1", i, mem_re, mem_we, stall, mem_addr);
      end
      tick();
      total++;
      if ({resp_valid, stall, resp_rdata} !== {2'b11, exps[i]}) begin
        bad++; $display("FAIL ld%0d_c2 got v=%b st=%b d=%h exp v=1 st=1 d=%h", i, resp_valid, stall, resp_rdata, exps[i]);
      end
      tick();
      total++;
      if ({resp_valid, stall, resp_rdata} !== {2'b00, exps[i]}) begin
        bad++; $display("FAIL ld%0d_hold got v=%b st=%b d=%h exp v=0 st=0 d=%h", i, resp_valid, stall, resp_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_sub_store();
    logic [31:0] wds  [2] = '{32'h1234_56AA, 32'h5555_BEEF};
    logic [2:0]  f3s  [2] = '{F3_B, F3_H};
    logic [31:0] adrs [2] = '{32'h0000_000D, 32'h0000_0012};
    logic [4:0]  wix  [2] = '{5'd3, 5'd4};
    logic [31:0] exps [2] = '{32'h1122_AA44, 32'hBEEF_F00D};
    mem[3] = 32'h1122_3344;
    mem[4] = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, f3s[i], adrs[i], wds[i]);
      tick();
      drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
      total++;
      if ({mem_re, mem_we, stall, mem_addr} !== {3'b101, wix[i]}) begin
        bad++; $display("FAIL rmw%0d_c1 got re=%b we=%b st=%b a=%0d", i, mem_re, mem_we, stall, mem_addr);
      end
      tick();
      total++;
      if ({mem_re, mem_we, stall, mem_addr, mem_wdata} !== {3'b011, wix[i], exps[i]}) begin
        bad++; $display("FAIL rmw%0d_c2 got re=%b we=%b st=%b a=%0d d=%h exp d=%h", i, mem_re, mem_we, stall, mem_addr, mem_wdata, exps[i]);
      end
      tick();
    end
    drive(1, 0, 1, F3_W, 32'h0000_000C, 32'h0);
    tick();
    drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
    tick();
    total++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h1122_AA44}) begin
      bad++; $display("FAIL rmw_readback got v=%b d=%h exp v=1 d=1122aa44", resp_valid, resp_rdata);
    end
    tick();
  endtask

  task automatic test_misaligned();
    logic        wrs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [4] = '{F3_W, F3_H, 3'b011, 3'b100};
    logic [31:0] adrs [4] = '{32'h2, 32'h3, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(1, wrs[i], !wrs[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
      tick();
      drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
      total++;
      if ({misaligned, mem_re, mem_we, stall} !== 4'b1000) begin
        bad++; $display("FAIL mis%0d_c1 got mis=%b re=%b we=%b st=%b exp 1 0 0 0", i, misaligned, mem_re, mem_we, stall);
      end
      tick();
      total++;
      if ({misaligned, mem_re, mem_we, stall} !== 4'b0000) begin
        bad++; $display("FAIL mis%0d_c2 got mis=%b re=%b we=%b st=%b exp 0 0 0 0", i, misaligned, mem_re, mem_we, stall);
      end
    end
  endtask

  task automatic test_rst_mid();
    mem[5] = 32'h5A5A_1234;
    we_cnt = 0;
    drive(1, 1, 0, F3_H, 32'h0000_0014, 32'h0000_FFFF);
    tick();
    drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    total++;
    if ({mem_re, mem_we} !== 2'b00) begin bad++; $display("FAIL rstmid_gate got re=%b we=%b exp 0 0", mem_re, mem_we); end
    tick();
    total++;
    if ({stall, resp_valid, misaligned, mem_re, mem_we, mem_addr, mem_wdata} !== 42'h0) begin
      bad++; $display("FAIL rstmid_out got st=%b v=%b mis=%b re=%b we=%b a=%0d d=%h exp all 0",
                      stall, resp_valid, misaligned, mem_re, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    tick(); tick();
    drive(1, 0, 1, F3_W, 32'h0000_0014, 32'h0);
    tick();
    drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
    tick();
    total++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h5A5A_1234}) begin
      bad++; $display("FAIL rstmid_readback got v=%b d=%h exp v=1 d=5a5a1234", resp_valid, resp_rdata);
    end
    total++;
    if (we_cnt !== 0) begin bad++; $display("FAIL rstmid_nowrite got=%0d exp=0", we_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic        e_st [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 0};
    logic        e_re [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    logic        e_we [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
    logic        e_rv [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [4:0]  e_a  [9] = '{0, 6, 6, 0, 6, 6, 0, 7, 0};
    logic [31:0] e_d  [9] = '{0, 0, 32'h0102_0304, 0, 0, 32'h0102_7704, 0, 32'h0BAD_F00D, 0};
    mem[6] = 32'h0102_0304;
    mem[7] = 32'h0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      drive(1, 0, 1, F3_W, 32'h0000_0018, 32'h0);
      else if (c <= 3) drive(1, 1, 0, F3_B, 32'h0000_0019, 32'h0000_0077);
      else if (c <= 6) drive(1, 1, 0, F3_W, 32'h0000_001C, 32'h0BAD_F00D);
      else             drive(0, 0, 0, 3'b0, 32'h0, 32'h0);
      total++;
      if ({stall, mem_re, mem_we, resp_valid} !== {e_st[c], e_re[c], e_we[c], e_rv[c]}) begin
        bad++; $display("FAIL b2b_c%0d_ctrl got st=%b re=%b we=%b rv=%b exp %b %b %b %b", c, stall, mem_re, mem_we,
                        resp_valid, e_st[c], e_re[c], e_we[c], e_rv[c]);
      end
      if (e_re[c] || e_we[c]) begin
        total++;
        if (mem_addr !== e_a[c]) begin bad++; $display("FAIL b2b_c%0d_addr got=%0d exp=%0d", c, mem_addr, e_a[c]); end
      end
      if (e_we[c]) begin
        total++;
        if (mem_wdata !== e_d[c]) begin bad++; $display("FAIL b2b_c%0d_wdata got=%h exp=%h", c, mem_wdata, e_d[c]); end
      end
      if (e_rv[c]) begin
        total++;
        if (resp_rdata !== e_d[c]) begin bad++; $display("FAIL b2b_c%0d_rdata got=%h exp=%h", c, resp_rdata, e_d[c]); end
      end
      tick();
    end
    total++;
    if ({mem[6], mem[7]} !== {32'h0102_7704, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL b2b_mem got=%h %h exp=01027704 0badf00d", mem[6], mem[7]);
    end
  endtask

  initial begin
    we_cnt = 0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_sw();
    test_loads();
    test_sub_store();
    test_misaligned();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
